// File: rtl/axi_lite_cmd_master_pkg.sv
// Shared types and constants for the AXI4-Lite command master.
// Contents:
//   AXI_LITE_WORD_WIDTH / AXI_LITE_ADDR_WIDTH  bus widths
//   AXI_RESP_TIMEOUT                           response code reported when the watchdog fires
//   axi_mst_state_e                            master FSM states
//   axi_lite_output / axi_lite_input           master->slave and slave->master channel bundles
package axi_lite_cmd_master_pkg;

  localparam int AXI_LITE_WORD_WIDTH = 32;
  localparam int AXI_LITE_ADDR_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } axi_mst_state_e;

  typedef struct packed {
    logic                             awvalid;
    logic [AXI_LITE_ADDR_WIDTH-1:0]   awaddr;
    logic                             wvalid;
    logic [AXI_LITE_WORD_WIDTH-1:0]   wdata;
    logic [AXI_LITE_WORD_WIDTH/8-1:0] wstrb;
    logic                             bready;
    logic                             arvalid;
    logic [AXI_LITE_ADDR_WIDTH-1:0]   araddr;
    logic                             rready;
  } axi_lite_output;

  typedef struct packed {
    logic                           awready;
    logic                           wready;
    logic                           bvalid;
    logic [1:0]                     bresp;
    logic                           arready;
    logic                           rvalid;
    logic [AXI_LITE_WORD_WIDTH-1:0] rdata;
    logic [1:0]                     rresp;
  } axi_lite_input;

endpackage

// File: rtl/axi_lite_cmd_master_watchdog.sv
// Saturating wait-state counter for the AXI-Lite master.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        restart the count (asserted on every FSM state change)
//   en         count this cycle (FSM is waiting on the slave)
//   expired    count has reached LIMIT-1 while enabled; never asserts when LIMIT == 0
module axi_lite_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt;

  // Holds at LAST instead of wrapping so a stalled FSM cannot miss the expiry.
  always_ff @(posedge clk) begin
    if (rst || clr)                cnt <= '0;
    else if (en && (cnt != LAST))  cnt <= cnt + CW'(1);
  end

  assign expired = (LIMIT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: converts a valid/ready command port into single-beat
// AXI-Lite reads/writes and returns one registered response per command.
// A watchdog abandons transactions whose slave stops responding.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready           command handshake; cmd_ready only in IDLE
//   cmd_write/addr/wdata      command payload (1 = write)
//   rsp_valid/ready           response handshake; response held until accepted
//   rsp_write/rdata/resp      echo of cmd_write, read data, bresp/rresp (2'b11 on timeout)
//   rsp_timeout               response was produced by the watchdog
//   busy                      FSM not in IDLE
//   AXI_LITE_output           registered master->slave channels
//   AXI_LITE_input            slave->master channels
module axi_lite_cmd_master
  import axi_lite_cmd_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [AXI_LITE_WORD_WIDTH-1:0] cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_write,
  output logic [AXI_LITE_WORD_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_timeout,
  output logic                           busy,
  output axi_lite_output                 AXI_LITE_output,
  input  axi_lite_input                  AXI_LITE_input
);

  axi_mst_state_e state, state_d;
  logic aw_done, w_done;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;
  logic accept, rsp_hs;
  logic wd_en, wd_clr, expired, to_fire;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  assign accept = cmd_valid && cmd_ready;
  assign rsp_hs = rsp_valid && rsp_ready;

  assign aw_hs = AXI_LITE_output.awvalid && AXI_LITE_input.awready;
  assign w_hs  = AXI_LITE_output.wvalid  && AXI_LITE_input.wready;
  assign b_hs  = AXI_LITE_output.bready  && AXI_LITE_input.bvalid;
  assign ar_hs = AXI_LITE_output.arvalid && AXI_LITE_input.arready;
  assign r_hs  = AXI_LITE_output.rready  && AXI_LITE_input.rvalid;

  // A channel counts as finished if it completed earlier or handshakes now.
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done  || w_hs;

  assign wd_en = (state == WR_AW_W) || (state == WR_B) ||
                 (state == RD_AR)   || (state == RD_R);

  // A real handshake on the same cycle as expiry wins over the timeout.
  always_comb begin
    to_fire = 1'b0;
    if (expired) begin
      case (state)
        WR_AW_W: to_fire = !(aw_fin && w_fin);
        WR_B:    to_fire = !b_hs;
        RD_AR:   to_fire = !ar_hs;
        RD_R:    to_fire = !r_hs;
        default: to_fire = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = cmd_write ? WR_AW_W : RD_AR;
      WR_AW_W: if (aw_fin && w_fin) state_d = WR_B;
               else if (to_fire)    state_d = RESP;
      WR_B:    if (b_hs || to_fire) state_d = RESP;
      RD_AR:   if (ar_hs)           state_d = RD_R;
               else if (to_fire)    state_d = RESP;
      RD_R:    if (r_hs || to_fire) state_d = RESP;
      RESP:    if (rsp_hs)          state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  assign wd_clr = (state_d != state);

  axi_lite_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      AXI_LITE_output <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      rsp_write       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_resp        <= '0;
      rsp_timeout     <= 1'b0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (accept) begin
          rsp_write   <= cmd_write;
          rsp_rdata   <= '0;
          rsp_resp    <= '0;
          rsp_timeout <= 1'b0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          if (cmd_write) begin
            AXI_LITE_output.awvalid <= 1'b1;
            AXI_LITE_output.awaddr  <= AXI_LITE_ADDR_WIDTH'(cmd_addr);
            AXI_LITE_output.wvalid  <= 1'b1;
            AXI_LITE_output.wdata   <= cmd_wdata;
            AXI_LITE_output.wstrb   <= '1;
          end else begin
            AXI_LITE_output.arvalid <= 1'b1;
            AXI_LITE_output.araddr  <= AXI_LITE_ADDR_WIDTH'(cmd_addr);
          end
        end
        WR_AW_W: begin
          // AW and W retire independently; each valid drops on its own handshake.
          if (aw_hs) begin
            AXI_LITE_output.awvalid <= 1'b0;
            aw_done                 <= 1'b1;
          end
          if (w_hs) begin
            AXI_LITE_output.wvalid <= 1'b0;
            w_done                 <= 1'b1;
          end
          if (aw_fin && w_fin) AXI_LITE_output.bready <= 1'b1;
        end
        WR_B: if (b_hs) begin
          AXI_LITE_output.bready <= 1'b0;
          rsp_resp               <= AXI_LITE_input.bresp;
        end
        RD_AR: if (ar_hs) begin
          AXI_LITE_output.arvalid <= 1'b0;
          AXI_LITE_output.rready  <= 1'b1;
        end
        RD_R: if (r_hs) begin
          AXI_LITE_output.rready <= 1'b0;
          rsp_rdata              <= AXI_LITE_input.rdata;
          rsp_resp               <= AXI_LITE_input.rresp;
        end
        default: ;
      endcase
      // Abandon the transaction: drop every valid/ready so late beats are ignored.
      if (to_fire) begin
        AXI_LITE_output.awvalid <= 1'b0;
        AXI_LITE_output.wvalid  <= 1'b0;
        AXI_LITE_output.bready  <= 1'b0;
        AXI_LITE_output.arvalid <= 1'b0;
        AXI_LITE_output.rready  <= 1'b0;
        rsp_rdata               <= '0;
        rsp_resp                <= AXI_RESP_TIMEOUT;
        rsp_timeout             <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master with a configurable responder.
module tb_axi_lite_cmd_master;
  import axi_lite_cmd_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  axi_lite_output axo;
  axi_lite_input  axin;

  axi_lite_cmd_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_write       (rsp_write),
    .rsp_rdata       (rsp_rdata),
    .rsp_resp        (rsp_resp),
    .rsp_timeout     (rsp_timeout),
    .busy            (busy),
    .AXI_LITE_output (axo),
    .AXI_LITE_input  (axin)
  );

  initial forever #5 clk = ~clk;

  // Responder configuration: ready delays in cycles of visible valid (0 = ready always high,
  // -1 for AR = never ready); b/r delays are cycles after the enabling handshake(s).
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  logic [31:0] r_data_cfg = '0;
  logic [1:0]  r_resp_cfg = '0, b_resp_cfg = '0;
  bit          late_r = 1'b0;
  int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;

  // Responder: inputs change on negedge; handshakes of the previous posedge are
  // reconstructed from the values presented during that cycle.
  initial begin
    axi_lite_output po;
    axi_lite_input  pi;
    int aw_age, w_age, ar_age, b_age, r_age;
    bit aw_seen, w_seen, b_pend, r_pend;
    po = '0; pi = '0; axin = '0;
    aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
    aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        axin = '0; po = '0; pi = '0;
        aw_age = 0; w_age = 0; ar_age = 0; b_age = 0; r_age = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
      end else begin
        if (po.awvalid && pi.awready) begin n_aw++; cap_awaddr = po.awaddr; aw_seen = 1; aw_age = 0; end
        if (po.wvalid && pi.wready) begin n_w++; cap_wdata = po.wdata; w_seen = 1; w_age = 0; end
        if (po.arvalid && pi.arready) begin n_ar++; cap_araddr = po.araddr; r_pend = 1; r_age = 0; ar_age = 0; end
        if (po.bready && pi.bvalid) begin n_b++; b_pend = 0; end
        if (po.rready && pi.rvalid) begin n_r++; r_pend = 0; end
        if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_age = 0; end

        axin.awready = (aw_dly == 0) || (axo.awvalid && aw_age >= aw_dly);
        axin.wready  = (w_dly == 0)  || (axo.wvalid && w_age >= w_dly);
        axin.arready = (ar_dly == 0) || (ar_dly > 0 && axo.arvalid && ar_age >= ar_dly);
        axin.bvalid  = b_pend && (b_age >= b_dly);
        axin.bresp   = b_resp_cfg;
        axin.rvalid  = late_r || (r_pend && r_age >= r_dly);
        axin.rdata   = late_r ? 32'hBAD0_BAD0 : r_data_cfg;
        axin.rresp   = r_resp_cfg;
        if (axo.awvalid) aw_age++;
        if (axo.wvalid)  w_age++;
        if (axo.arvalid) ar_age++;
        if (b_pend)      b_age++;
        if (r_pend)      r_age++;
        po = axo; pi = axin;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of cycle N+1.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("rsp_seen", rsp_valid, 1);
  endtask

  logic [2:0] exp5 [6] = '{3'b110, 3'b110, 3'b010, 3'b010, 3'b010, 3'b001};

  initial begin
    int cyc, b_aw, b_w, b_b, b_r;
    bit held, stable, rdy_low, no_to;
    logic [31:0] snap;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    chk("rst_axo_zero", |axo, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write
    b_aw = n_aw; b_w = n_w; b_b = n_b;
    send(1'b1, 32'h43C8_0000, 32'hDEAD_BEEF);
    chk("wr_aw_w_valid", {axo.awvalid, axo.wvalid, axo.bready}, 3'b110);
    chk("wr_awaddr", axo.awaddr, 32'h43C8_0000);
    chk("wr_wdata", axo.wdata, 32'hDEAD_BEEF);
    chk("wr_busy", busy, 1);
    wait_rsp(cyc);
    chk("wr_latency", cyc, 2);
    chk("wr_rsp", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 32'h0});
    @(negedge clk);
    chk("wr_rsp_done", {rsp_valid, cmd_ready}, 2'b01);
    chk("wr_beats", {8'(n_aw - b_aw), 8'(n_w - b_w), 8'(n_b - b_b)}, 24'h010101);
    chk("wr_slave_cap", {cap_awaddr, cap_wdata}, {32'h43C8_0000, 32'hDEAD_BEEF});

    // Read, rvalid 3 cycles after arready
    r_dly = 2; r_data_cfg = 32'h1; r_resp_cfg = 2'b00;
    send(1'b0, 32'h43C8_001C, 32'h0);
    chk("rd_arvalid", axo.arvalid, 1);
    chk("rd_araddr", axo.araddr, 32'h43C8_001C);
    wait_rsp(cyc);
    chk("rd_latency", cyc, 4);
    chk("rd_rsp", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 1'b0, 2'b00, 32'h1});
    @(negedge clk);

    // Read with SLVERR
    r_dly = 0; r_data_cfg = 32'h55; r_resp_cfg = 2'b10;
    send(1'b0, 32'h43C8_0004, 32'h0);
    wait_rsp(cyc);
    chk("rd_err_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b10, 32'h55});
    chk("rd_err_slave_addr", cap_araddr, 32'h43C8_0004);
    @(negedge clk);
    r_resp_cfg = 2'b00;

    // Write with awready at +1, wready at +4
    aw_dly = 1; w_dly = 4;
    b_aw = n_aw; b_w = n_w;
    send(1'b1, 32'h43C8_0010, 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("split_wr_c%0d", i + 1), {axo.awvalid, axo.wvalid, axo.bready}, exp5[i]);
      @(negedge clk);
    end
    wait_rsp(cyc);
    chk("split_wr_latency", cyc, 0);
    chk("split_wr_rsp", {rsp_write, rsp_timeout, rsp_resp}, 4'b1000);
    @(negedge clk);
    chk("split_wr_beats", {8'(n_aw - b_aw), 8'(n_w - b_w)}, 16'h0101);
    chk("split_wr_cap", cap_wdata, 32'h1234_5678);
    aw_dly = 0; w_dly = 0;

    // Response backpressure for 20 cycles
    rsp_ready = 1'b0; r_data_cfg = 32'hA5A5_A5A5;
    send(1'b0, 32'h43C8_0008, 32'h0);
    wait_rsp(cyc);
    snap = rsp_rdata;
    held = 1; stable = 1; rdy_low = 1; no_to = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rsp_valid) held = 0;
      if (rsp_rdata !== snap || rsp_resp !== 2'b00) stable = 0;
      if (cmd_ready) rdy_low = 0;
      if (rsp_timeout) no_to = 0;
    end
    chk("bp_rsp_held", held, 1);
    chk("bp_payload_stable", stable, 1);
    chk("bp_cmd_ready_low", rdy_low, 1);
    chk("bp_no_timeout", no_to, 1);
    chk("bp_rdata", rsp_rdata, 32'hA5A5_A5A5);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {rsp_valid, cmd_ready}, 2'b01);

    // Watchdog: slave never asserts arready
    ar_dly = -1; b_r = n_r;
    send(1'b0, 32'h43C8_0020, 32'h0);
    chk("to_arvalid", axo.arvalid, 1);
    wait_rsp(cyc);
    chk("to_latency", cyc, 16);
    chk("to_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b11, 32'h0});
    chk("to_axo_quiet", {axo.awvalid, axo.wvalid, axo.bready, axo.arvalid, axo.rready}, 5'b0);
    @(negedge clk);
    late_r = 1'b1;
    rdy_low = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (axo.rready || axo.arvalid || busy || rsp_valid) rdy_low = 0;
    end
    late_r = 1'b0;
    chk("to_late_r_ignored", rdy_low, 1);
    chk("to_no_r_beat", n_r - b_r, 0);
    ar_dly = 0;
    @(negedge clk);

    // Reset while waiting in WR_B, then a normal read
    b_dly = 50;
    send(1'b1, 32'h43C8_0030, 32'hCAFE_F00D);
    @(negedge clk);
    chk("rst_mid_in_wr_b", {busy, axo.bready}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_ready", {cmd_ready, busy, rsp_valid}, 3'b100);
    chk("rst_mid_rsp_fields", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, 0);
    chk("rst_mid_axo_zero", |axo, 0);
    rst = 1'b0; b_dly = 0; r_data_cfg = 32'h0000_1234;
    @(negedge clk);
    send(1'b0, 32'h43C8_0040, 32'h0);
    wait_rsp(cyc);
    chk("post_rst_rd", {rsp_write, rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 1'b0, 2'b00, 32'h1234});
    @(negedge clk);
    chk("post_rst_idle", {rsp_valid, cmd_ready}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running, expected finish");
    $fatal(1, "time limit");
  end

endmodule
